// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect and IF/ID outputs.
// The id_misalign signal exists only when FETCH_MISALIGN_CHECK_EN is defined.
`default_nettype none

interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        id_misalign;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, id_stall,
    output id_valid, id_instr, id_pc, id_pc_plus4, id_misalign
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, id_stall,
    input  id_valid, id_instr, id_pc, id_pc_plus4, id_misalign
  );
`else
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, id_stall,
    output id_valid, id_instr, id_pc, id_pc_plus4
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, id_stall,
    input  id_valid, id_instr, id_pc, id_pc_plus4
  );
`endif
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I PC/fetch FSM with IF/ID register, one-entry skid buffer and redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise id_misalign and halt fetch.
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        skid_valid_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic        id_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;

  logic        req_valid;
  logic        handshake;
  logic        rsp_live;
  logic        if_free;
  logic        consume;
  logic [31:0] redirect_tgt;

  assign req_valid = !rst && (state_q == S_IDLE) && !skid_valid_q;
  assign handshake = req_valid && bus.imem_req_ready;
  assign rsp_live  = (state_q == S_WAIT) && bus.imem_rsp_valid;
  assign if_free   = !id_valid_q || !bus.id_stall;
  assign consume   = id_valid_q && !bus.id_stall;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  logic redirect_bad;

  assign redirect_tgt    = bus.redirect_pc;
  assign redirect_bad    = (bus.redirect_pc[1:0] != 2'b00);
  assign bus.id_misalign = misalign_q;
`else
  logic unused_redirect_lsb;

  assign redirect_tgt        = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      // Redirect overrides stall and discards any same-cycle response.
      pc_q         <= redirect_tgt;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      case (state_q)
        S_WAIT:  state_q <= rsp_live ? S_IDLE : S_DRAIN;
        S_DRAIN: state_q <= bus.imem_rsp_valid ? S_IDLE : S_DRAIN;
        default: state_q <= handshake ? S_DRAIN : S_IDLE;
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
      if (redirect_bad) begin
        id_valid_q <= 1'b1;
        id_pc_q    <= bus.redirect_pc;
        misalign_q <= 1'b1;
        state_q    <= S_HALT;
      end
`endif
    end else begin
      if (handshake) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + 32'd4;
        state_q  <= S_WAIT;
      end
      if ((state_q == S_DRAIN) && bus.imem_rsp_valid) begin
        state_q <= S_IDLE;
      end
      if (rsp_live) begin
        state_q <= S_IDLE;
        if (if_free) begin
          id_valid_q <= 1'b1;
          id_instr_q <= bus.imem_rsp_data;
          id_pc_q    <= req_pc_q;
        end else begin
          skid_valid_q <= 1'b1;
          skid_instr_q <= bus.imem_rsp_data;
          skid_pc_q    <= req_pc_q;
        end
      end else if (consume) begin
        if (skid_valid_q) begin
          id_instr_q   <= skid_instr_q;
          id_pc_q      <= skid_pc_q;
          skid_valid_q <= 1'b0;
        end else begin
          id_valid_q <= 1'b0;
          id_instr_q <= NOP_INSTR;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_q <= 1'b0;
`endif
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.id_valid       = id_valid_q;
  assign bus.id_instr       = id_instr_q;
  assign bus.id_pc          = id_pc_q;
  assign bus.id_pc_plus4    = id_pc_q + 32'd4;

endmodule

`default_nettype wire
